// File: rtl/data_memory_ctrl.sv
// Parametrised single-port synchronous data RAM with byte-lane writes, a read-valid strobe,
// an out-of-range error pulse and a clear-on-reset INIT sequence that zeroes every word.
module data_memory_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     adr,
    input  logic [DATA_WIDTH-1:0]     datain,
    input  logic [DATA_WIDTH/8-1:0]   be,
    input  logic                      w,
    input  logic                      r,
    output logic                      ready,
    output logic [DATA_WIDTH-1:0]     dataout,
    output logic                      rvalid,
    output logic                      err
);

    localparam int                    NB       = DATA_WIDTH / 8;
    localparam int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [IDX_W-1:0]        r_clr_cnt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_ready;
    logic                    w_in_range;
    logic                    w_accept_w;
    logic                    w_accept_r;
    logic                    w_wr_err;
    logic [IDX_W-1:0]        w_idx;
    logic [IDX_W-1:0]        w_rd_idx;
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    logic                    w_fin_valid;
    logic                    w_fin_err;
    logic [DATA_WIDTH-1:0]   w_fin_data;

    logic                    r_rvalid;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_dataout;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        case (r_state)
            INIT: if (r_clr_cnt == LAST_IDX) w_next_state = RUN;
            RUN:  w_ready = 1'b1;
            default: w_next_state = INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= INIT;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == INIT) r_clr_cnt <= r_clr_cnt + IDX_W'(1);
        end
    end

    assign w_in_range = ({1'b0, adr} < DEPTH_W);
    assign w_accept_w = w_ready && w;
    assign w_accept_r = w_ready && r;
    assign w_wr_err   = w_accept_w && !r && !w_in_range;
    assign w_idx      = adr[IDX_W-1:0];
    assign w_rd_idx   = w_in_range ? w_idx : '0;

    // Write-first: a simultaneous read returns the byte-merged word being written.
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        w_merged  = w_rd_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) w_merged[8*i +: 8] = datain[8*i +: 8];
        end
        w_rd_data = '0;
        if (w_in_range) w_rd_data = w_accept_w ? w_merged : w_rd_word;
    end

    // NOTE: the array has no reset; INIT zeroes it one word per clock instead.
    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_accept_w && w_in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) r_mem[w_idx][8*i +: 8] <= datain[8*i +: 8];
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_p_valid;
            logic                  r_p_err;
            logic [DATA_WIDTH-1:0] r_p_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_p_valid <= 1'b0;
                    r_p_err   <= 1'b0;
                    r_p_data  <= '0;
                end else begin
                    r_p_valid <= w_accept_r;
                    r_p_err   <= w_accept_r && !w_in_range;
                    r_p_data  <= w_rd_data;
                end
            end

            assign w_fin_valid = r_p_valid;
            assign w_fin_err   = r_p_err;
            assign w_fin_data  = r_p_data;
        end else begin : g_lat1
            assign w_fin_valid = w_accept_r;
            assign w_fin_err   = w_accept_r && !w_in_range;
            assign w_fin_data  = w_rd_data;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
            r_dataout <= '0;
        end else begin
            r_rvalid <= w_fin_valid;
            r_err    <= w_fin_err | w_wr_err;
            if (w_fin_valid) r_dataout <= w_fin_data;
        end
    end

    assign ready   = w_ready;
    assign rvalid  = r_rvalid;
    assign err     = r_err;
    assign dataout = r_dataout;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomised bench for data_memory_ctrl: two configurations (8b/256/lat1 and 32b/200/lat2)
// share one stimulus stream and are checked every cycle against a behavioural memory model.
module tb_data_memory_ctrl;

    localparam int A_DEPTH = 256;
    localparam int A_LAT   = 1;
    localparam int B_DEPTH = 200;
    localparam int B_LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  adr = '0;
    logic [31:0] datain = '0;
    logic [3:0]  be = '0;
    logic        w = 1'b0;
    logic        r = 1'b0;

    logic        a_ready, a_rvalid, a_err;
    logic [7:0]  a_dataout;
    logic        b_ready, b_rvalid, b_err;
    logic [31:0] b_dataout;

    data_memory_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(A_DEPTH), .READ_LATENCY(A_LAT)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .adr(adr), .datain(datain[7:0]), .be(be[0:0]),
        .w(w), .r(r), .ready(a_ready), .dataout(a_dataout), .rvalid(a_rvalid), .err(a_err)
    );

    data_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(B_DEPTH), .READ_LATENCY(B_LAT)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .adr(adr), .datain(datain), .be(be),
        .w(w), .r(r), .ready(b_ready), .dataout(b_dataout), .rvalid(b_rvalid), .err(b_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        e;
        logic [31:0] d;
    } rec_t;

    rec_t        qa[$];
    rec_t        qb[$];
    logic [31:0] mem_m [2][256];
    int          cnt [2];
    logic [31:0] last_d [2];
    logic        exp_v [2];
    logic        exp_e [2];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour of one request edge: after DEPTH clearing cycles the memory is live.
    task automatic model_edge(input int id, input int depth, input int nb,
                              output rec_t rc, output logic wr_err);
        rc     = '0;
        wr_err = 1'b0;
        if (cnt[id] >= depth) begin
            if (w && int'(adr) < depth) begin
                for (int b = 0; b < nb; b++)
                    if (be[b]) mem_m[id][adr][8*b +: 8] = datain[8*b +: 8];
            end
            if (w && !r && int'(adr) >= depth) wr_err = 1'b1;
            if (r) begin
                rc.v = 1'b1;
                rc.e = (int'(adr) >= depth);
                rc.d = (int'(adr) < depth) ? mem_m[id][adr] : 32'h0;
            end
        end
        cnt[id]++;
    endtask

    task automatic check_outputs();
        check("a_ready",   {31'b0, a_ready},  {31'b0, cnt[0] >= A_DEPTH});
        check("a_rvalid",  {31'b0, a_rvalid}, {31'b0, exp_v[0]});
        check("a_err",     {31'b0, a_err},    {31'b0, exp_e[0]});
        check("a_dataout", {24'b0, a_dataout}, last_d[0]);
        check("b_ready",   {31'b0, b_ready},  {31'b0, cnt[1] >= B_DEPTH});
        check("b_rvalid",  {31'b0, b_rvalid}, {31'b0, exp_v[1]});
        check("b_err",     {31'b0, b_err},    {31'b0, exp_e[1]});
        check("b_dataout", b_dataout,          last_d[1]);
    endtask

    task automatic tick();
        rec_t rc, out;
        logic we;
        @(posedge clk);
        if (rst_n) begin
            model_edge(0, A_DEPTH, 1, rc, we);
            qa.push_back(rc);
            out = (qa.size() == A_LAT) ? qa.pop_front() : '0;
            exp_v[0] = out.v;
            exp_e[0] = out.e | we;
            if (out.v) last_d[0] = out.d;

            model_edge(1, B_DEPTH, 4, rc, we);
            qb.push_back(rc);
            out = (qb.size() == B_LAT) ? qb.pop_front() : '0;
            exp_v[1] = out.v;
            exp_e[1] = out.e | we;
            if (out.v) last_d[1] = out.d;
        end
        #1;
        check_outputs();
    endtask

    task automatic apply(input logic iw, input logic ir, input logic [7:0] ia,
                         input logic [31:0] id, input logic [3:0] ib);
        w = iw; r = ir; adr = ia; datain = id; be = ib;
        tick();
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 8'($urandom), $urandom, 4'($urandom));
    endtask

    // Asynchronous reset; the model forgets pending reads and memory reads as zero after INIT.
    task automatic do_reset();
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0; last_d[i] = '0; exp_v[i] = 1'b0; exp_e[i] = 1'b0;
            for (int j = 0; j < 256; j++) mem_m[i][j] = '0;
        end
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Run through INIT with random (ignored until ready) requests and time ready's rise.
    task automatic run_init();
        int first_a = -1;
        int first_b = -1;
        for (int i = 1; i <= 300 && first_a < 0; i++) begin
            apply(1'($urandom), 1'($urandom), 8'($urandom_range(100, 199)), $urandom, 4'($urandom));
            if (a_ready && first_a < 0) first_a = i;
            if (b_ready && first_b < 0) first_b = i;
        end
        check("a_ready_latency", first_a, A_DEPTH);
        check("b_ready_latency", first_b, B_DEPTH);
    endtask

    initial begin
        do_reset();
        run_init();

        // First read straight after INIT returns the cleared word.
        apply(1'b0, 1'b1, 8'h0A, 32'h0, 4'h0);
        check("a_first_read", {24'b0, a_dataout}, 32'h00);

        apply(1'b1, 1'b0, 8'h0A, 32'h0000_0055, 4'h1);
        apply(1'b0, 1'b1, 8'h0A, 32'h0, 4'h0);
        check("a_read_back", {24'b0, a_dataout}, 32'h55);
        apply(1'b0, 1'b1, 8'h00, 32'h0, 4'h0);
        check("a_read_zero", {24'b0, a_dataout}, 32'h00);
        idle();

        // Byte-lane merge.
        apply(1'b1, 1'b0, 8'd3, 32'hDEADBEEF, 4'hF);
        apply(1'b1, 1'b0, 8'd3, 32'h11223344, 4'b0101);
        apply(1'b0, 1'b1, 8'd3, 32'h0, 4'h0);
        idle();
        check("b_merge", b_dataout, 32'hDE22BE44);
        idle();

        // Out of range for the 200-deep instance, in range for the 256-deep one.
        apply(1'b1, 1'b0, 8'd210, 32'hFFFF_FFFF, 4'hF);
        apply(1'b0, 1'b1, 8'd210, 32'h0, 4'h0);
        apply(1'b0, 1'b1, 8'd10, 32'h0, 4'h0);
        idle();
        idle();

        // Preload then back-to-back reads.
        for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, 8'(i), 32'h10 + 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 8'(i), 32'h0, 4'h0);
        idle();
        idle();

        // Write and read together: write-first.
        apply(1'b1, 1'b1, 8'd5, 32'h0000_00A5, 4'hF);
        idle();
        check("b_write_first", b_dataout, 32'h0000_00A5);
        idle();

        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
                  8'($urandom_range(0, 255)), $urandom, 4'($urandom));
        end
        idle();
        idle();

        // Reset with a read in flight, then confirm memory was re-cleared.
        apply(1'b1, 1'b0, 8'h0A, 32'h7777_7777, 4'hF);
        apply(1'b0, 1'b1, 8'h0A, 32'h0, 4'h0);
        do_reset();
        check("b_no_rvalid_after_reset", {31'b0, b_rvalid}, 32'h0);
        run_init();
        apply(1'b0, 1'b1, 8'h0A, 32'h0, 4'h0);
        check("a_recleared", {24'b0, a_dataout}, 32'h00);
        idle();
        check("b_recleared", b_dataout, 32'h0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
